// File: rtl/soc_bus_arbiter.sv
// Round-robin multi-master front end for the shared SoC bus controller.
// One transaction in flight at a time; read data captured after a fixed controller latency.
module soc_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int RD_LATENCY  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              busy,
  output logic                              bus_we,
  output logic [ADDR_WIDTH-1:0]             bus_addr,
  output logic [DATA_WIDTH-1:0]             bus_wdata,
  input  logic [DATA_WIDTH-1:0]             bus_rdata
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state_reg;
  logic [GW-1:0]           grant_reg;
  logic [GW-1:0]           last_grant_reg;
  logic                    we_reg;
  logic [CW-1:0]           cnt_reg;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_MASTERS];
  logic [GW-1:0]           winner;
  logic [GW-1:0]           cand_w;
  logic                    found;
  int                      cand_i;
  logic [NUM_MASTERS-1:0]  ack_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search begins one past the last winner so every requester is served within NUM_MASTERS grants.
  always_comb begin
    winner = last_grant_reg;
    found  = 1'b0;
    cand_i = 0;
    cand_w = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand_i = int'(last_grant_reg) + k;
      if (cand_i >= NUM_MASTERS) cand_i = cand_i - NUM_MASTERS;
      cand_w = GW'(cand_i);
      if (!found && m_req[cand_w]) begin
        found  = 1'b1;
        winner = cand_w;
      end
    end
  end

  assign ack_onehot = NUM_MASTERS'(1) << grant_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_RST;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      m_ack          <= '0;
      m_rdata        <= '0;
      busy           <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg      <= ISSUE;
            busy           <= 1'b1;
            grant_reg      <= winner;
            last_grant_reg <= winner;
            we_reg         <= m_we[winner];
            bus_we         <= m_we[winner];
            bus_addr       <= addr_arr[winner];
            bus_wdata      <= wdata_arr[winner];
          end
        end
        ISSUE: begin
          bus_we <= 1'b0;
          if (we_reg) begin
            state_reg <= DONE;
            m_ack     <= ack_onehot;
          end else begin
            state_reg <= WAIT;
            cnt_reg   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
          // Last latency cycle: the controller's data is valid on this edge only.
          if (cnt_reg == CW'(1)) begin
            m_rdata   <= bus_rdata;
            state_reg <= DONE;
            m_ack     <= ack_onehot;
          end
        end
        DONE: begin
          m_ack     <= '0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench: default 2-master arbiter via vector table and ack scoreboard,
// plus a 4-master, 4-cycle-latency instance for latency and round-robin sequences.
module tb_soc_bus_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    m_req, m_we, m_ack;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata, bus_wdata, bus_rdata;
  logic          busy, bus_we;
  logic [AW-1:0] bus_addr;

  logic [3:0]    m_req4, m_we4, m_ack4;
  logic [4*AW-1:0] m_addr4;
  logic [4*DW-1:0] m_wdata4;
  logic [DW-1:0] m_rdata4, bus_wdata4, bus_rdata4;
  logic          busy4, bus_we4;
  logic [AW-1:0] bus_addr4;

  soc_bus_arbiter dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  soc_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .m_req(m_req4), .m_we(m_we4), .m_addr(m_addr4),
    .m_wdata(m_wdata4), .m_ack(m_ack4), .m_rdata(m_rdata4), .busy(busy4),
    .bus_we(bus_we4), .bus_addr(bus_addr4), .bus_wdata(bus_wdata4), .bus_rdata(bus_rdata4)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] ack;
    logic [7:0] rdata;
    int         cycle;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard monitor for the 2-master instance.
  always @(negedge clk) begin
    if (reset === 1'b0 && m_ack !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got %b expected none", m_ack);
      end else begin
        mon_e = sb.pop_front();
        check("ack_onehot", 32'(m_ack), 32'(mon_e.ack));
        check("ack_rdata", 32'(m_rdata), 32'(mon_e.rdata));
        if (mon_e.cycle >= 0) check("ack_cycle", cyc_cnt, mon_e.cycle);
        $display("ack m_ack=%b m_rdata=0x%02h cycle=%0d", m_ack, m_rdata, cyc_cnt);
      end
    end
  end

  typedef struct {
    int         m;
    logic       we;
    logic [16:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic [1:0] exp_ack;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int  c0;
    bit  seen;
    @(posedge clk); #1;
    c0 = cyc_cnt;
    m_we[v.m] = v.we;
    m_addr[v.m*AW +: AW] = v.addr;
    m_wdata[v.m*DW +: DW] = v.wdata;
    m_req[v.m] = 1'b1;
    bus_rdata = ~v.rd;
    sb.push_back('{v.exp_ack, v.exp_rdata, c0 + v.exp_lat});
    seen = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(posedge clk); #1;
      bus_rdata = (k == 2) ? v.rd : ~v.rd;
      @(negedge clk);
      check("bus_we", 32'(bus_we), (k == 1) ? 32'(v.we) : 32'd0);
      check("busy", 32'(busy), 32'd1);
      check("bus_addr", 32'(bus_addr), 32'(v.addr));
      if (v.we && k == 1) check("bus_wdata", 32'(bus_wdata), 32'(v.wdata));
      if (m_ack !== 2'b00) seen = 1;
    end
    m_req = '0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout: got no ack expected ack from master %0d", v.m);
    end
    $display("txn m=%0d we=%0b addr=0x%05h wdata=0x%02h rd=0x%02h", v.m, v.we, v.addr, v.wdata, v.rd);
  endtask

  initial begin
    int c0;
    int acks;
    bit seen;
    logic [3:0] order4 [4];
    logic [3:0] exp4 [4];

    vecs[0] = '{0, 1'b1, 17'h1_0004, 8'hA5, 8'h00, 2'b01, 8'h00, 2};
    vecs[1] = '{1, 1'b0, 17'h0_0010, 8'h00, 8'h3C, 2'b10, 8'h3C, 3};
    vecs[2] = '{0, 1'b0, 17'h1_FFFF, 8'h00, 8'h5A, 2'b01, 8'h5A, 3};
    vecs[3] = '{1, 1'b1, 17'h0_0000, 8'hFF, 8'h00, 2'b10, 8'h5A, 2};
    vecs[4] = '{1, 1'b0, 17'h1_2345, 8'h00, 8'h00, 2'b10, 8'h00, 3};
    vecs[5] = '{0, 1'b1, 17'h0_ABCD, 8'h11, 8'h00, 2'b01, 8'h00, 2};

    reset = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; bus_rdata = '0;
    m_req4 = '0; m_we4 = '0; m_addr4 = '0; m_wdata4 = '0; bus_rdata4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst4_busy", 32'(busy4), 32'd0);
    check("rst4_rdata", 32'(m_rdata4), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during WAIT abandons the read with no ack.
    @(posedge clk); #1;
    m_we[1] = 1'b0; m_addr[AW +: AW] = 17'h0_0020; m_req[1] = 1'b1;
    bus_rdata = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m_req = '0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bus_we", 32'(bus_we), 32'd0);
    check("midrst_ack", 32'(m_ack), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(m_ack), 32'd0);
    end
    check("midrst_rdata", 32'(m_rdata), 32'd0);
    $display("txn reset during read wait");

    // Contention from reset with both masters holding requests back-to-back.
    @(posedge clk); #1;
    c0 = cyc_cnt;
    m_we = 2'b11;
    m_addr = {17'h0_0200, 17'h0_0100};
    m_wdata = {8'h22, 8'h11};
    m_req = 2'b11;
    sb.push_back('{2'b01, 8'h00, c0 + 2});
    sb.push_back('{2'b10, 8'h00, c0 + 5});
    sb.push_back('{2'b01, 8'h00, c0 + 8});
    sb.push_back('{2'b10, 8'h00, c0 + 11});
    acks = 0;
    for (int k = 1; k <= 30 && acks < 4; k++) begin
      @(negedge clk);
      if (m_ack !== 2'b00) acks++;
    end
    m_req = '0;
    if (acks < 4) begin
      checks++;
      failures++;
      $display("FAIL contention_timeout: got %0d acks expected 4", acks);
    end
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("txn contention masters 0,1 acks=%0d", acks);

    // 4-master instance: master 3 read with 4-cycle latency.
    @(posedge clk); #1;
    m_we4[3] = 1'b0;
    m_addr4[3*AW +: AW] = 17'h1_5555;
    m_req4[3] = 1'b1;
    bus_rdata4 = 8'h3C;
    seen = 0;
    for (int k = 1; k <= 15 && !seen; k++) begin
      @(posedge clk); #1;
      bus_rdata4 = (k == 5) ? 8'hC3 : 8'h3C;
      @(negedge clk);
      check("lat4_bus_we", 32'(bus_we4), 32'd0);
      if (m_ack4 !== 4'b0000) begin
        seen = 1;
        check("lat4_ack", 32'(m_ack4), 32'b1000);
        check("lat4_rdata", 32'(m_rdata4), 32'hC3);
        check("lat4_cycle", k, 6);
        check("lat4_addr", 32'(bus_addr4), 32'h1_5555);
      end
    end
    m_req4 = '0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL lat4_timeout: got no ack expected ack in cycle 6");
    end
    @(negedge clk);
    check("lat4_rdata_hold", 32'(m_rdata4), 32'hC3);
    $display("txn lat4 m=3 read addr=0x15555 rdata=0x%02h", m_rdata4);

    // 4-master round robin: masters 1 and 3 held high must alternate.
    exp4[0] = 4'b0010; exp4[1] = 4'b1000; exp4[2] = 4'b0010; exp4[3] = 4'b1000;
    @(posedge clk); #1;
    m_we4 = 4'b1010;
    m_req4 = 4'b1010;
    acks = 0;
    for (int k = 1; k <= 30 && acks < 4; k++) begin
      @(negedge clk);
      if (m_ack4 !== 4'b0000) begin
        order4[acks] = m_ack4;
        acks++;
      end
    end
    m_req4 = '0;
    if (acks < 4) begin
      checks++;
      failures++;
      $display("FAIL rr4_timeout: got %0d acks expected 4", acks);
    end else begin
      for (int i = 0; i < 4; i++) check("rr4_order", 32'(order4[i]), 32'(exp4[i]));
    end
    $display("txn rr4 masters 1,3 acks=%0d", acks);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
# soc_bus_arbiter

Parametrised multi-master front end for the SoC shared bus, replacing the single hard-wired domain-to-busctl connection. It accepts read/write requests from NUM_MASTERS CPU domains, grants one at a time using fair round-robin arbitration, and drives one transaction to the bus controller. It returns read data and a one-cycle acknowledge to the granted master, honouring the controller's fixed read latency.

## Interface
- NUM_MASTERS, 2, number of requesting domains; must be at least 1.
- ADDR_WIDTH, 17, bus address width.
- DATA_WIDTH, 8, bus data width.
- RD_LATENCY, 1, cycles from the address being presented to the controller until read data is valid; must be at least 1.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_req  input  NUM_MASTERS  per-master request; held high until ack.
- m_we  input  NUM_MASTERS  per-master write enable (1 = write).
- m_addr  input  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wdata  input  NUM_MASTERS*DATA_WIDTH  packed write data, same packing as m_addr.
- m_ack  output  NUM_MASTERS  one-hot, one-cycle completion pulse.
- m_rdata  output  DATA_WIDTH  read data; shared by all masters and valid while m_ack is high for a read.
- busy  output  1  high whenever the FSM is not in IDLE.
- bus_we  output  1  write strobe to the bus controller.
- bus_addr  output  ADDR_WIDTH  address to the bus controller.
- bus_wdata  output  DATA_WIDTH  write data to the bus controller.
- bus_rdata  input  DATA_WIDTH  read data from the bus controller.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any m_req bit is set at the clock edge, select the winner and go to ISSUE.
  - On that edge, register the winner's index, m_we, m_addr and m_wdata into grant, bus_addr and bus_wdata.
  - With no request, stay in IDLE; bus_addr and bus_wdata hold their last values.
- **Arbitration (round-robin)**
  - Search starts at (last_grant + 1) mod NUM_MASTERS and takes the first set m_req bit.
  - last_grant updates to the winner on entry to ISSUE.
  - last_grant resets to NUM_MASTERS-1, so master 0 has first priority.
  - When NUM_MASTERS = 1 the arbiter degenerates to a pass-through with the same FSM.
- **ISSUE** (exactly one cycle)
  - bus_we = 1 only if the latched request is a write.
  - A write goes next to DONE.
  - A read loads the latency counter with RD_LATENCY and goes to WAIT.
- **WAIT**
  - The counter decrements each cycle.
  - On the edge where the counter equals 1, capture bus_rdata into m_rdata and go to DONE.
  - The counter is $clog2(RD_LATENCY+1) bits wide and does not wrap.
- **DONE** (one cycle)
  - m_ack[grant] = 1; all other ack bits are 0.
  - Next state is always IDLE.
- bus_addr is stable from ISSUE through DONE. bus_we is 0 in every state except ISSUE.
- m_rdata holds its value until the next read capture; it is not updated by writes.
- **Master protocol**
  - m_we, m_addr and m_wdata must be stable while m_req is high.
  - If m_req is still high in the cycle after m_ack, it is a new, back-to-back request and competes normally in IDLE.
  - Dropping m_req before m_ack is a protocol violation: the latched transaction still completes and is acked.
- **Reset**
  - Asserting reset at any time, including mid-transaction, forces IDLE immediately.
  - The in-flight transaction is abandoned and no ack is issued.
  - Reset values: m_ack = 0, m_rdata = 0, busy = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, grant = 0, last_grant = NUM_MASTERS-1, counter = 0.

## Timing
- Request first sampled high at edge 0 (FSM in IDLE).
- **Write:** ISSUE in cycle 1 (bus_we = 1); DONE and ack in cycle 2.
- **Read:** ISSUE in cycle 1; WAIT in cycles 2 .. 1+RD_LATENCY; ack with valid m_rdata in cycle 2+RD_LATENCY (cycle 3 at the default).
- **Throughput:** the FSM returns to IDLE after DONE, so each transaction costs one idle cycle. Minimum spacing is 3 cycles per write and 3+RD_LATENCY cycles per read.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset mid-read:** reset asserted during WAIT -> next cycle busy = 0, bus_we = 0, m_ack = 0; no ack ever appears for that read.
- **Single write:** master 0 writes addr 0x1_0004, data 0xA5 -> bus_we = 1 for exactly one cycle with bus_addr = 0x1_0004 and bus_wdata = 0xA5; m_ack = 2'b01 two cycles after the request is sampled.
- **Single read, RD_LATENCY = 1:** master 1 reads addr 0x0_0010, controller returns 0x3C -> m_ack = 2'b10 with m_rdata = 0x3C in cycle 3; bus_we stays 0 throughout.
- **Contention:** both masters request simultaneously from reset -> master 0 is acked first, then master 1. If master 0 re-requests back-to-back, grants alternate 0,1,0,1; neither master is starved.
- **Latency sweep, RD_LATENCY = 4, NUM_MASTERS = 4:** master 3 reads -> ack in cycle 6 with captured data. The bus_rdata value present after the capture edge is not reflected in m_rdata.
